// File: rtl/serial_pkg.sv
// Shared types and constants for the serial transmitter arbitration blocks.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_TX = 2'd1,
        SEND    = 2'd2
    } state_t;

    localparam int BYTE_W          = 8;
    localparam int DEF_GAP_TIMEOUT = 1023;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo N.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW:0]   sum;
    logic [IW-1:0] k_idx;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        sum    = '0;
        k_idx  = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr} + (IW+1)'(i);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            k_idx = sum[IW-1:0];
            if (!any && req[k_idx]) begin
                any           = 1'b1;
                idx           = k_idx;
                onehot[k_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_tx_arbiter.sv
// Shares one byte-serial transmitter among NUM_REQ message streams; a grant
// is held until the owner's LAST byte has been taken by the transmitter.
module serial_tx_arbiter
    import serial_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int GAP_TIMEOUT = DEF_GAP_TIMEOUT,
    parameter int GAP_W       = 10
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [NUM_REQ-1:0]        REQ_VALID,
    input  logic [BYTE_W*NUM_REQ-1:0] REQ_DATA,
    input  logic [NUM_REQ-1:0]        REQ_LAST,
    output logic [NUM_REQ-1:0]        REQ_READY,
    output logic [NUM_REQ-1:0]        GRANT,
    output logic [BYTE_W-1:0]         TX_DATA,
    output logic                      TX_SEND,
    input  logic                      TX_READY,
    output logic                      GAP_ERR,
    output logic                      BUSY
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t              state;
    state_t              next_state;
    logic [IDX_W-1:0]    grant_idx;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    next_ptr;
    logic [GAP_W-1:0]    gap_cnt;
    logic                last_flag;
    logic [NUM_REQ-1:0]  pick_onehot;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;
    logic                owner_valid;
    logic                owner_last;
    logic [BYTE_W-1:0]   owner_data;
    logic                gap_expired;
    logic                accept;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_rr_pick (
        .req    (REQ_VALID),
        .ptr    (rr_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                owner_valid = REQ_VALID[i];
                owner_last  = REQ_LAST[i];
                owner_data  = REQ_DATA[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Timeout has priority over a byte arriving in the same cycle.
    assign gap_expired = (gap_cnt == GAP_W'(GAP_TIMEOUT));
    assign accept      = (state == WAIT_TX) && TX_READY && owner_valid && !gap_expired;
    assign next_ptr    = (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pick_any) next_state = WAIT_TX;
            WAIT_TX: begin
                if (gap_expired) begin
                    next_state = IDLE;
                end else if (accept) begin
                    next_state = SEND;
                end
            end
            SEND:    if (!TX_READY) next_state = last_flag ? IDLE : WAIT_TX;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        REQ_READY = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept && (grant_idx == IDX_W'(i))) begin
                REQ_READY[i] = 1'b1;
            end
        end
        BUSY = |GRANT;
    end

    // TX_DATA only changes on accept, so it stays stable throughout SEND.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            GRANT     <= '0;
            grant_idx <= '0;
            rr_ptr    <= '0;
            gap_cnt   <= '0;
            last_flag <= 1'b0;
            TX_DATA   <= '0;
            TX_SEND   <= 1'b0;
            GAP_ERR   <= 1'b0;
        end else begin
            GAP_ERR <= 1'b0;
            case (state)
                IDLE: begin
                    gap_cnt <= '0;
                    if (pick_any) begin
                        GRANT     <= pick_onehot;
                        grant_idx <= pick_idx;
                    end
                end
                WAIT_TX: begin
                    if (gap_expired) begin
                        GRANT   <= '0;
                        GAP_ERR <= 1'b1;
                        rr_ptr  <= next_ptr;
                        gap_cnt <= '0;
                    end else if (accept) begin
                        TX_DATA   <= owner_data;
                        last_flag <= owner_last;
                        TX_SEND   <= 1'b1;
                        gap_cnt   <= '0;
                    end else if (!owner_valid) begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                SEND: begin
                    if (!TX_READY) begin
                        TX_SEND <= 1'b0;
                        if (last_flag) begin
                            GRANT  <= '0;
                            rr_ptr <= next_ptr;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench for serial_tx_arbiter with queue-based requesters and a
// behavioural transmitter that drops READY for a fixed frame after each byte.
module tb_serial_tx_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int GAP_TIMEOUT = 15;
    localparam int GAP_W       = 4;
    localparam int FRAME       = 4;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_last  = '0;
    logic [31:0] req_data  = '0;
    logic [3:0]  req_ready;
    logic [3:0]  grant;
    logic [7:0]  tx_data;
    logic        tx_send;
    logic        tx_ready;
    logic        gap_err;
    logic        busy;

    logic        tx_hold = 1'b0;
    logic        model_ready;
    int          frame_cnt;

    logic [8:0]  req_mem [4][64];
    logic [5:0]  wr_ptr [4] = '{default: '0};
    logic [5:0]  rd_ptr [4] = '{default: '0};
    logic [7:0]  log_data [$];
    logic [3:0]  log_grant [$];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  mask;
        int          n;
        logic [15:0] order;
    } vec_t;

    vec_t vecs [5];

    serial_tx_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .GAP_TIMEOUT (GAP_TIMEOUT),
        .GAP_W       (GAP_W)
    ) dut (
        .CLK       (clk),
        .RESET     (reset),
        .REQ_VALID (req_valid),
        .REQ_DATA  (req_data),
        .REQ_LAST  (req_last),
        .REQ_READY (req_ready),
        .GRANT     (grant),
        .TX_DATA   (tx_data),
        .TX_SEND   (tx_send),
        .TX_READY  (tx_ready),
        .GAP_ERR   (gap_err),
        .BUSY      (busy)
    );

    always #5 clk = ~clk;

    assign tx_ready = model_ready && !tx_hold;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            model_ready <= 1'b1;
            frame_cnt   <= 0;
        end else if (tx_ready && tx_send) begin
            log_data.push_back(tx_data);
            log_grant.push_back(grant);
            model_ready <= 1'b0;
            frame_cnt   <= FRAME;
        end else if (!model_ready) begin
            if (frame_cnt <= 1) model_ready <= 1'b1;
            frame_cnt <= frame_cnt - 1;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (req_ready[i]) rd_ptr[i] <= rd_ptr[i] + 6'd1;
        end
    end

    // Requester outputs change only on the falling edge, away from DUT sampling.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            req_valid[i] = (wr_ptr[i] != rd_ptr[i]);
            {req_last[i], req_data[i*8 +: 8]} = req_mem[i][rd_ptr[i]];
        end
    end

    task automatic applyStimulus(input int req, input logic [7:0] data, input logic last);
        req_mem[req][wr_ptr[req]] = {last, data};
        wr_ptr[req] = wr_ptr[req] + 6'd1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic bit queuesEmpty();
        bit e = 1'b1;
        for (int i = 0; i < 4; i++) if (wr_ptr[i] != rd_ptr[i]) e = 1'b0;
        return e;
    endfunction

    task automatic waitLog(input int n, input string name);
        int cyc = 0;
        while (log_data.size() < n && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput(name, 32'(log_data.size() >= n), 32'd1);
    endtask

    task automatic waitIdle(input string name);
        int cyc  = 0;
        bit done = 1'b0;
        while (!done && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
            done = !busy && !tx_send && queuesEmpty();
        end
        checkOutput(name, 32'(done), 32'd1);
    endtask

    task automatic checkLogEntry(input string name, input int pos, input logic [7:0] d, input logic [3:0] g);
        checkOutput({name, "_data"}, 32'(log_data[pos]), 32'(d));
        checkOutput({name, "_grant"}, 32'(log_grant[pos]), 32'(g));
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_grant"}, 32'(grant), 32'd0);
        checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        checkOutput({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        checkOutput({tag, "_tx_send"}, 32'(tx_send), 32'd0);
        checkOutput({tag, "_gap_err"}, 32'(gap_err), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base;
        int cyc;
        int cnt_a;
        int cnt_b;
        int idx;
        logic [7:0] exp_d;

        // order holds winner indices, one nibble per slot, slot 0 lowest.
        vecs[0] = '{mask: 4'b1111, n: 4, order: 16'h0321};
        vecs[1] = '{mask: 4'b0101, n: 2, order: 16'h0002};
        vecs[2] = '{mask: 4'b1000, n: 1, order: 16'h0003};
        vecs[3] = '{mask: 4'b0110, n: 2, order: 16'h0021};
        vecs[4] = '{mask: 4'b1001, n: 2, order: 16'h0003};

        #2 reset = 1'b0;
        #1 checkResetOutputs("rst");
        #20 reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("idle_grant", 32'(grant), 32'd0);

        base = log_data.size();
        applyStimulus(0, 8'h41, 1'b0);
        applyStimulus(0, 8'h42, 1'b0);
        applyStimulus(0, 8'h43, 1'b1);
        waitLog(base + 3, "a_log");
        checkLogEntry("a0", base + 0, 8'h41, 4'b0001);
        checkLogEntry("a1", base + 1, 8'h42, 4'b0001);
        checkLogEntry("a2", base + 2, 8'h43, 4'b0001);
        waitIdle("a_idle");

        for (int e = 0; e < 5; e++) begin
            base = log_data.size();
            for (int i = 0; i < 4; i++) begin
                if (vecs[e].mask[i]) applyStimulus(i, 8'(128 + 16*e + i), 1'b1);
            end
            waitLog(base + vecs[e].n, $sformatf("tbl%0d_log", e));
            for (int k = 0; k < vecs[e].n; k++) begin
                idx   = int'(vecs[e].order[4*k +: 4]);
                exp_d = 8'(128 + 16*e + idx);
                checkLogEntry($sformatf("tbl%0d_%0d", e, k), base + k, exp_d, 4'(4'b0001 << idx));
            end
            waitIdle($sformatf("tbl%0d_idle", e));
        end

        applyStimulus(1, 8'h77, 1'b1);
        waitIdle("p2_idle");
        base = log_data.size();
        applyStimulus(1, 8'h31, 1'b0);
        applyStimulus(1, 8'h32, 1'b1);
        applyStimulus(3, 8'h61, 1'b0);
        applyStimulus(3, 8'h62, 1'b1);
        waitLog(base + 4, "rr_log");
        checkLogEntry("rr0", base + 0, 8'h61, 4'b1000);
        checkLogEntry("rr1", base + 1, 8'h62, 4'b1000);
        checkLogEntry("rr2", base + 2, 8'h31, 4'b0010);
        checkLogEntry("rr3", base + 3, 8'h32, 4'b0010);
        waitIdle("rr_idle");

        base = log_data.size();
        for (int b = 0; b < 5; b++) applyStimulus(2, 8'(8'h10 + b), 1'(b == 4));
        applyStimulus(0, 8'h99, 1'b1);
        waitLog(base + 6, "lock_log");
        for (int b = 0; b < 5; b++) checkLogEntry($sformatf("lock%0d", b), base + b, 8'(8'h10 + b), 4'b0100);
        checkLogEntry("lock5", base + 5, 8'h99, 4'b0001);
        waitIdle("lock_idle");

        base = log_data.size();
        applyStimulus(1, 8'h55, 1'b0);
        waitLog(base + 1, "gap_log");
        cyc = 0;
        while (tx_send && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput("gap_enter_wait", 32'(tx_send), 32'd0);
        cnt_a = 0;
        for (int c = 1; c <= GAP_TIMEOUT; c++) begin
            @(posedge clk); #1;
            if (gap_err) cnt_a++;
        end
        checkOutput("gap_early", 32'(cnt_a), 32'd0);
        applyStimulus(1, 8'hA1, 1'b1);
        applyStimulus(2, 8'hB2, 1'b1);
        @(posedge clk); #1;
        checkOutput("gap_pulse", 32'(gap_err), 32'd1);
        checkOutput("gap_grant", 32'(grant), 32'd0);
        checkOutput("gap_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        checkOutput("gap_pulse_end", 32'(gap_err), 32'd0);
        waitLog(base + 3, "gap_after_log");
        checkLogEntry("gap_next0", base + 1, 8'hB2, 4'b0100);
        checkLogEntry("gap_next1", base + 2, 8'hA1, 4'b0010);
        waitIdle("gap_idle");

        tx_hold = 1'b1;
        base = log_data.size();
        applyStimulus(0, 8'hD0, 1'b1);
        cyc = 0;
        while (grant != 4'b0001 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput("stall_grant", 32'(grant), 32'b0001);
        cnt_a = 0;
        cnt_b = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (req_ready != 4'b0000) cnt_a++;
            if (gap_err) cnt_b++;
        end
        checkOutput("stall_req_ready", 32'(cnt_a), 32'd0);
        checkOutput("stall_gap_err", 32'(cnt_b), 32'd0);
        #1 tx_hold = 1'b0;
        #1 checkOutput("stall_accept", 32'(req_ready), 32'b0001);
        waitLog(base + 1, "stall_log");
        checkLogEntry("stall", base, 8'hD0, 4'b0001);
        waitIdle("stall_idle");

        applyStimulus(3, 8'hE1, 1'b0);
        applyStimulus(3, 8'hE2, 1'b0);
        applyStimulus(3, 8'hE3, 1'b1);
        cyc = 0;
        while (!tx_send && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput("mid_send", 32'(tx_send), 32'd1);
        #3 reset = 1'b0;
        #1 checkResetOutputs("midrst");
        for (int i = 0; i < 4; i++) wr_ptr[i] = rd_ptr[i];
        #12 reset = 1'b1;
        @(posedge clk); #1;
        base = log_data.size();
        applyStimulus(0, 8'hF0, 1'b1);
        applyStimulus(1, 8'hF1, 1'b1);
        waitLog(base + 2, "post_rst_log");
        checkLogEntry("post_rst0", base + 0, 8'hF0, 4'b0001);
        checkLogEntry("post_rst1", base + 1, 8'hF1, 4'b0010);
        waitIdle("post_rst_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_tx_arbiter.md
Name: serial_tx_arbiter

Overview:
- Shares one byte-serial transmitter (8-bit data, send strobe, ready status) among NUM_REQ independent byte-stream requesters.
- Grants one requester at a time. The grant is locked until that requester's message (terminated by LAST) is fully handed to the transmitter.
- Grant order is round-robin.
- Sits between the command/telemetry producers and the serial transmitter on the CLK domain.
- Sequences the transmitter's SEND/READY handshake so that no byte is dropped or duplicated.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GAP_TIMEOUT, 1023, maximum CLK cycles a granted requester may leave VALID low mid-message before its grant is revoked.
- GAP_W, 10, width of the gap counter; must satisfy 2^GAP_W > GAP_TIMEOUT.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-low reset.
- REQ_VALID  in  NUM_REQ  per-requester byte valid.
- REQ_DATA  in  8*NUM_REQ  per-requester byte; requester i occupies [8i+7:8i].
- REQ_LAST  in  NUM_REQ  marks the final byte of a message; sampled with its byte.
- REQ_READY  out  NUM_REQ  byte-accept strobe, one-hot or zero.
- GRANT  out  NUM_REQ  current owner, one-hot or zero.
- TX_DATA  out  8  byte to the transmitter.
- TX_SEND  out  1  send request to the transmitter.
- TX_READY  in  1  transmitter idle/ready status.
- GAP_ERR  out  1  one-cycle pulse when a grant is revoked by timeout.
- BUSY  out  1  high whenever GRANT != 0.

Behaviour:
- Reset (RESET low, asynchronous) forces the following. All hold until the first CLK edge after RESET rises.
  - state=IDLE.
  - GRANT=0, REQ_READY=0.
  - TX_DATA=8'h00, TX_SEND=0.
  - GAP_ERR=0, BUSY=0.
  - rr pointer=0, gap counter=0, last flag=0.
- IDLE:
  - If any REQ_VALID is set, pick the first set bit searching upward from the rr pointer, wrapping modulo NUM_REQ.
  - Register it into GRANT and go to WAIT_TX.
  - If nothing is valid, stay in IDLE.
  - Arbitration costs one cycle.
- WAIT_TX, owner g:
  - REQ_READY[g] is high, combinationally, iff TX_READY && REQ_VALID[g]. This is the accept cycle.
  - On accept:
    - TX_DATA <= REQ_DATA[g].
    - last flag <= REQ_LAST[g].
    - TX_SEND <= 1.
    - gap counter cleared.
    - go to SEND.
  - While REQ_VALID[g]=0, the gap counter increments each cycle.
  - When the gap counter equals GAP_TIMEOUT:
    - clear GRANT and pulse GAP_ERR for one cycle.
    - rr pointer <= g+1, modulo NUM_REQ.
    - go to IDLE.
  - REQ_VALID high with TX_READY low does not advance the gap counter. The stall is attributed to the transmitter.
- SEND:
  - TX_SEND and TX_DATA are held constant. The transmitter samples data continuously while ready, so TX_DATA must not change in this state.
  - When TX_READY is sampled low, the byte counts as taken:
    - TX_SEND <= 0.
    - If the last flag is set: GRANT <= 0, rr pointer <= g+1, go to IDLE.
    - Otherwise return to WAIT_TX.
  - There is no timeout in SEND. The transmitter always accepts within one baud period.
- Throughput: at most one byte per transmitter frame. The next accept requires TX_READY to return high.
- REQ_READY is never asserted for a non-owner. Non-owners hold VALID/DATA stable until accepted.
- A requester dropping VALID after its last byte has no effect. A single-byte message is VALID with LAST set on its first byte.
- Simultaneous GAP_TIMEOUT expiry and a VALID arrival in the same cycle: timeout wins and the byte is not accepted.
- If RESET is asserted mid-byte, the transmitter is reset by the same signal and the partial message is discarded.

Decomposition:
- Shared package (serial_pkg) holds:
  - state encoding: IDLE=0, WAIT_TX=1, SEND=2.
  - BYTE_W=8.
  - default GAP_TIMEOUT.
- One sub-module: rr_pick. It is combinational.
  - Inputs: request vector, pointer.
  - Outputs: one-hot winner, winner index, any-valid.
  - It is reused later by other shared-resource arbiters.
- Gap counter, state register and data register stay in the top.

Test Plan:
- Single requester 0 sends a 3-byte message, 0x41 0x42 0x43 with LAST on 0x43, against a behavioural transmitter model -> three TX_SEND episodes in order; GRANT=4'b0001 throughout; BUSY drops after 0x43 is taken; rr pointer=1.
- Requesters 1 and 3 both VALID in IDLE with pointer=2 -> requester 3 granted first, then requester 1. Their bytes are never interleaved.
- Requester 2 streams 0x10..0x14 while requester 0 stays VALID -> requester 0 is not granted until requester 2's LAST byte, 0x14, is taken.
- Requester 1 sends 0x55 without LAST, then holds VALID low with GAP_TIMEOUT=15 -> exactly 15 cycles after entering WAIT_TX, GAP_ERR pulses one cycle; GRANT=0; next grant goes to requester 2 or higher.
- TX_READY held low for 200 cycles while requester 0 is VALID in WAIT_TX -> no REQ_READY, no GAP_ERR. On TX_READY rising, the byte is accepted on that cycle.
- RESET pulsed low mid-SEND, asynchronously and not on a CLK edge -> outputs reach their reset values immediately; after release, a fresh arbitration starts from pointer 0.
